full_adder: RTL and testbench

- 1-bit full adder with an optional output register, in the combinational arithmetic library.
- Packed inputs {a, b, cin} produce packed outputs {cout, sum}, so outputs equals the binary count of ones in inputs.
- Built from two half_adder slices plus an OR for carry-out.
- Clocked wrapper uses the design's single clock domain.

---
 rtl/fa_pkg.sv | 20 ++
 rtl/half_adder.sv | 18 +
 rtl/full_adder.sv | 90 +++++++++
 tb/tb_full_adder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fa_pkg.sv
// -----------------------------------------------------------------------------
// fa_pkg
// Shared constants and types for the full adder slice.
//   A_IDX / B_IDX / CIN_IDX : bit positions of a, b, cin in the packed operand
//   SUM_IDX / COUT_IDX      : bit positions of sum, cout in the packed result
//   fa_in_t                 : packed operand {a, b, cin}
//   fa_out_t                : packed result  {cout, sum}
// -----------------------------------------------------------------------------
package fa_pkg;

   localparam int A_IDX    = 2;
   localparam int B_IDX    = 1;
   localparam int CIN_IDX  = 0;
   localparam int SUM_IDX  = 0;
   localparam int COUT_IDX = 1;

   typedef logic [2:0] fa_in_t;
   typedef logic [1:0] fa_out_t;

endpackage : fa_pkg

// File: rtl/half_adder.sv
// -----------------------------------------------------------------------------
// half_adder
// One-bit half adder slice, purely combinational.
//   x, y : input operands
//   s    : sum   = x ^ y
//   c    : carry = x & y
// -----------------------------------------------------------------------------
module half_adder (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);

   assign s = x ^ y;
   assign c = x & y;

endmodule : half_adder

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full adder built from two half adders, with an optional output
// register selected by OUTPUT_REG.
//   clk       : system clock, rising edge
//   rst       : synchronous, active-high reset
//   inputs    : operands {a, b, cin}
//   in_valid  : qualifies inputs
//   outputs   : result {cout, sum} = a + b + cin
//   out_valid : outputs hold a valid result
// OUTPUT_REG = 1 gives one cycle of latency; 0 gives a combinational path
// where out_valid = in_valid & ~rst and outputs ignore rst.
// -----------------------------------------------------------------------------
module full_adder
   import fa_pkg::*;
#(
   parameter bit OUTPUT_REG = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] inputs,
   input  logic       in_valid,
   output logic [1:0] outputs,
   output logic       out_valid
);

   logic    w_s1;
   logic    w_c1;
   logic    w_sum;
   logic    w_c2;
   fa_out_t w_result;

   // First slice adds a and b; second folds in cin. The two carries can never
   // both be set, so an OR is enough to form cout.
   half_adder u_ha1 (
      .x (inputs[A_IDX]),
      .y (inputs[B_IDX]),
      .s (w_s1),
      .c (w_c1)
   );

   half_adder u_ha2 (
      .x (w_s1),
      .y (inputs[CIN_IDX]),
      .s (w_sum),
      .c (w_c2)
   );

   // NOTE: always_comb assigns a full default first so no latch can be
   // inferred if a bit is ever left unassigned on some path.
   always_comb begin
      w_result           = '0;
      w_result[SUM_IDX]  = w_sum;
      w_result[COUT_IDX] = w_c1 | w_c2;
   end

   generate
      if (OUTPUT_REG) begin : g_reg
         fa_out_t r_outputs;
         logic    r_out_valid;

         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         // Reset takes priority over in_valid; when idle the data register
         // holds, which also keeps X on idle inputs out of the result.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_outputs   <= '0;
               r_out_valid <= 1'b0;
            end else if (in_valid) begin
               r_outputs   <= w_result;
               r_out_valid <= 1'b1;
            end else begin
               r_out_valid <= 1'b0;
            end
         end

         assign outputs   = r_outputs;
         assign out_valid = r_out_valid;
      end else begin : g_comb
         // Clock has no role on the combinational path.
         logic w_unused_clk;
         assign w_unused_clk = clk;

         assign outputs   = w_result;
         assign out_valid = in_valid & ~rst;
      end
   endgenerate

endmodule : full_adder

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
// Self-checking bench for full_adder (registered and combinational builds)
// and for half_adder on its own. Expected {out_valid, outputs} values come
// from a small behavioural model, are queued when stimulus is driven, and are
// popped and compared when the DUT result is due.
// -----------------------------------------------------------------------------
module tb_full_adder;

   logic       clk;
   logic       rst;
   logic [2:0] r_in;
   logic       r_in_valid;
   logic [1:0] w_out;
   logic       w_out_valid;

   logic       c_rst;
   logic [2:0] c_in;
   logic       c_in_valid;
   logic [1:0] c_out;
   logic       c_out_valid;

   logic       ha_x;
   logic       ha_y;
   logic       ha_s;
   logic       ha_c;

   int checks = 0;
   int errors = 0;

   logic [2:0] exp_q[$];
   string      tag_q[$];

   // Model of the registered build's state.
   logic [1:0] m_out   = 2'b00;
   logic       m_valid = 1'b0;

   full_adder #(.OUTPUT_REG(1'b1)) dut_reg (
      .clk       (clk),
      .rst       (rst),
      .inputs    (r_in),
      .in_valid  (r_in_valid),
      .outputs   (w_out),
      .out_valid (w_out_valid)
   );

   full_adder #(.OUTPUT_REG(1'b0)) dut_comb (
      .clk       (clk),
      .rst       (c_rst),
      .inputs    (c_in),
      .in_valid  (c_in_valid),
      .outputs   (c_out),
      .out_valid (c_out_valid)
   );

   half_adder dut_ha (
      .x (ha_x),
      .y (ha_y),
      .s (ha_s),
      .c (ha_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0] ones(input logic [2:0] v);
      logic [1:0] n;
      n = 2'd0;
      for (int i = 0; i < 3; i++) n = n + {1'b0, v[i]};
      return n;
   endfunction

   task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic pop_check(input string tag_in, input logic [2:0] obs);
      logic [2:0] e;
      string      t;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: observed %b expected <empty scoreboard>", tag_in, obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check(t, obs, e);
      end
   endtask

   // One clock of the registered build: drive, update model, push, check.
   task automatic step(input string tag, input logic rst_v, input logic vld_v, input logic [2:0] in_v);
      rst        = rst_v;
      r_in_valid = vld_v;
      r_in       = in_v;
      if (rst_v) begin
         m_out   = 2'b00;
         m_valid = 1'b0;
      end else if (vld_v) begin
         m_out   = ones(in_v);
         m_valid = 1'b1;
      end else begin
         m_valid = 1'b0;
      end
      exp_q.push_back({m_valid, m_out});
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      pop_check(tag, {w_out_valid, w_out});
   endtask

   // One combinational sample: drive, push, wait 1 ns, check, finish slot.
   task automatic comb_step(input string tag, input logic rst_v, input logic vld_v, input logic [2:0] in_v);
      c_rst      = rst_v;
      c_in_valid = vld_v;
      c_in       = in_v;
      exp_q.push_back({vld_v & ~rst_v, ones(in_v)});
      tag_q.push_back(tag);
      #1;
      pop_check(tag, {c_out_valid, c_out});
      #9;
   endtask

   initial begin
      rst        = 1'b1;
      r_in       = 3'b000;
      r_in_valid = 1'b0;
      c_rst      = 1'b0;
      c_in       = 3'b000;
      c_in_valid = 1'b0;
      ha_x       = 1'b0;
      ha_y       = 1'b0;

      // Reset held with a valid 111 on the inputs: rst wins.
      step("reset_cyc0", 1'b1, 1'b1, 3'b111);
      step("reset_cyc1", 1'b1, 1'b1, 3'b111);
      step("reset_release", 1'b0, 1'b1, 3'b111);

      // Exhaustive sweep, one operand per cycle.
      for (int i = 0; i < 8; i++) begin
         step($sformatf("sweep_%0d", i), 1'b0, 1'b1, 3'(i));
      end

      // Idle hold, including X on the idle inputs.
      step("hold_load", 1'b0, 1'b1, 3'b011);
      step("hold_idle", 1'b0, 1'b0, 3'b111);
      step("hold_idle_x", 1'b0, 1'b0, 3'bxxx);

      // Mid-stream reset discards the in-flight operand.
      step("mid_load", 1'b0, 1'b1, 3'b110);
      step("mid_reset", 1'b1, 1'b1, 3'b101);
      step("mid_resume", 1'b0, 1'b1, 3'b101);

      // Combinational build: zero latency, valid follows in_valid & ~rst.
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         comb_step($sformatf("comb_%0d", i), 1'b0, (i % 3) != 2, 3'(i));
      end
      comb_step("comb_rst", 1'b1, 1'b1, 3'b111);

      // Half adder on its own: {s, c}.
      for (int i = 0; i < 4; i++) begin
         logic [1:0] v;
         v    = 2'(i);
         ha_x = v[1];
         ha_y = v[0];
         #1;
         check($sformatf("ha_%0d", i), {1'b0, ha_s, ha_c}, {1'b0, v[1] ^ v[0], v[1] & v[0]});
      end

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_full_adder
